sixteen_four_div: RTL and testbench

Sequential restoring divider that inverts the 16x4 multiplier datapath: it takes a 20-bit product-width dividend and a 4-bit divisor and recovers a 16-bit quotient plus a 4-bit remainder. It sits beside the approximate multiplier array as the rescale/normalisation unit, for example for averaging and for dividing accumulated products back to operand width. Quotient generation is iterative, one bit per clock, under a start/done handshake.

---
 rtl/sixteen_four_div.sv | 183 ++++++++++++++++++
 tb/tb_sixteen_four_div.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sixteen_four_div.sv
// Sequential restoring divider: 20-bit dividend / 4-bit divisor -> 16-bit quotient + 4-bit remainder.
// Latency: N+1 cycles from accept to done (N=20, or 20-TRUNC_BITS when truncating); divide-by-zero takes 1.
// Backpressure: start is taken only while ready (IDLE); requests at other times are dropped, not queued.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               request, accepted when ready=1
//   dividend[19:0]      unsigned dividend, sampled on the accept edge
//   divisor[3:0]        unsigned divisor, sampled on the accept edge
//   ready               high while IDLE
//   done                one-cycle pulse; results valid from this cycle and held until the next result
//   quotient[15:0]      unsigned quotient, saturated to 0xFFFF on overflow or divide-by-zero
//   remainder[3:0]      unsigned remainder
//   ovf                 true quotient exceeded 0xFFFF
//   dz                  divisor was zero
//
// Build option: define APPROX_DIV_TRUNC_EN to run only the top 20-TRUNC_BITS iterations.
// The low TRUNC_BITS quotient bits then read 0 and remainder reads 0.

module sixteen_four_div #(
  parameter int TRUNC_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] dividend,
  input  logic [3:0]  divisor,
  output logic        ready,
  output logic        done,
  output logic [15:0] quotient,
  output logic [3:0]  remainder,
  output logic        ovf,
  output logic        dz
);

`ifdef APPROX_DIV_TRUNC_EN
  localparam int TB = TRUNC_BITS;
`else
  // Truncation is disabled here; the parameter stays in the list so both builds share one interface.
  localparam int TB = 0 * TRUNC_BITS;
`endif

  localparam int         NITER    = 20 - TB;
  localparam logic [4:0] CNT_INIT = 5'(NITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] dvd_q, dvd_d;      // dividend, shifted left so the next bit is always at [19]
  logic [3:0]  dvs_q, dvs_d;
  logic [4:0]  prem_q, prem_d;    // partial remainder
  logic [19:0] quo_q, quo_d;      // quotient shift register, new bit enters at [0]
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  // One restoring step. prem_q < divisor <= 15, so after the shift it is < 30 and fits 5 bits;
  // prem_q[4] is therefore always 0 and only the low four bits carry into the shift.
  logic [4:0]  rem_sh;
  logic        rem_ge;
  logic [4:0]  rem_sub;
  logic [19:0] quo_sh;
  logic [19:0] quo_full;
  logic        quo_ovf;

  assign rem_sh  = {prem_q[3:0], dvd_q[19]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign quo_sh  = {quo_q[18:0], rem_ge};

  // When truncating, the computed bits are the top NITER bits of the true quotient;
  // realign them and zero-fill the skipped low bits.
  assign quo_full = quo_sh << TB;
  assign quo_ovf  = |quo_full[19:16];

  // Bits that are structurally always zero or shifted out before use.
  logic unused_bits;
  assign unused_bits = ^{prem_q[4], quo_q[19]};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != 4'd0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = 5'd0;
            quo_d   = 20'd0;
            cnt_d   = CNT_INIT;
            state_d = RUN;
          end else begin
            // Divide-by-zero bypasses the iteration entirely.
            quot_d  = 16'hFFFF;
            rem_d   = dividend[3:0];
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        dvd_d  = {dvd_q[18:0], 1'b0};
        prem_d = rem_ge ? rem_sub : rem_sh;
        quo_d  = quo_sh;
        if (cnt_q == 5'd0) begin
          // Last iteration: publish results on the same edge that enters DONE.
          quot_d  = quo_ovf ? 16'hFFFF : quo_full[15:0];
`ifdef APPROX_DIV_TRUNC_EN
          rem_d   = 4'd0;
`else
          rem_d   = prem_d[3:0];
`endif
          ovf_d   = quo_ovf;
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= 20'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 5'd0;
      quo_q   <= 20'd0;
      cnt_q   <= 5'd0;
      quot_q  <= 16'd0;
      rem_q   <= 4'd0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // All outputs are decoded from registers only.
  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_sixteen_four_div.sv
module tb_sixteen_four_div;

`ifdef APPROX_DIV_TRUNC_EN
  localparam bit TRUNC = 1'b1;
  localparam int N     = 16;
`else
  localparam bit TRUNC = 1'b0;
  localparam int N     = 20;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] dividend;
  logic [3:0]  divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [3:0]  remainder;
  logic        ovf;
  logic        dz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sixteen_four_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle T0+1; returns the cycle offset at which done was seen.
  task automatic wait_done(input bit poke, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (poke) begin
        // A start pulse with different operands while RUN must be ignored.
        start    = (lat == 5);
        dividend = 20'h00003;
        divisor  = 4'd1;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [19:0] a, input logic [3:0] b,
                        input logic [15:0] eq, input logic [3:0] er, input logic eo,
                        input logic ed, input int elat, input bit poke);
    int lat;
    @(negedge clk);
    check({tag, "_ready_idle"}, ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 20'hABCDE;
    divisor  = 4'h3;
    if (elat > 1) check({tag, "_ready_busy"}, ready, 0);
    wait_done(poke, lat);
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_dz"}, dz, ed);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_back"}, ready, 1);
    check({tag, "_q_hold"}, quotient, eq);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 20'd0;
    divisor  = 4'd0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dz", dz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("div7",  20'h021BE, 4'd7,  TRUNC ? 16'h04D0 : 16'h04D2, 4'd0, 1'b0, 1'b0, N + 1, 1'b0);
    run_op("div9",  20'h186A0, 4'd9,  TRUNC ? 16'h2B60 : 16'h2B67, TRUNC ? 4'd0 : 4'd1, 1'b0, 1'b0, N + 1, 1'b0);
    run_op("ovf",   20'hFFFFF, 4'hF,  16'hFFFF, 4'd0, 1'b1, 1'b0, N + 1, 1'b0);
    run_op("dz",    20'h12345, 4'd0,  16'hFFFF, 4'd5, 1'b0, 1'b1, 1, 1'b0);
    run_op("small", 20'h0000A, 4'd3,  TRUNC ? 16'h0000 : 16'h0003, TRUNC ? 4'd0 : 4'd1, 1'b0, 1'b0, N + 1, 1'b0);
    run_op("max16", 20'h0FFFF, 4'd1,  TRUNC ? 16'hFFF0 : 16'hFFFF, 4'd0, 1'b0, 1'b0, N + 1, 1'b0);
    run_op("ovfedge", 20'h10000, 4'd1, 16'hFFFF, 4'd0, 1'b1, 1'b0, N + 1, 1'b0);
    run_op("rem14", 20'h0001D, 4'hF,  TRUNC ? 16'h0000 : 16'h0001, TRUNC ? 4'd0 : 4'd14, 1'b0, 1'b0, N + 1, 1'b0);
    run_op("dz0",   20'h00000, 4'd0,  16'hFFFF, 4'd0, 1'b0, 1'b1, 1, 1'b0);
    run_op("poke",  20'h186A0, 4'd9,  TRUNC ? 16'h2B60 : 16'h2B67, TRUNC ? 4'd0 : 4'd1, 1'b0, 1'b0, N + 1, 1'b1);

    // Back-to-back: start held high is taken in the first IDLE cycle after DONE.
    @(negedge clk);
    start    = 1'b1;
    dividend = 20'h021BE;
    divisor  = 4'd7;
    @(negedge clk);
    wait_done(1'b0, lat);
    start = 1'b1;
    check("b2b_first_lat", lat, N + 1);
    check("b2b_first_q", quotient, TRUNC ? 16'h04D0 : 16'h04D2);
    @(negedge clk);
    check("b2b_idle_ready", ready, 1);
    dividend = 20'h186A0;
    divisor  = 4'd9;
    @(negedge clk);
    check("b2b_accepted", ready, 0);
    start = 1'b0;
    wait_done(1'b0, lat);
    check("b2b_second_lat", lat, N + 1);
    check("b2b_second_q", quotient, TRUNC ? 16'h2B60 : 16'h2B67);

    // Abort in the 10th RUN cycle.
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 20'hFFFFF;
    divisor  = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_ovf", ovf, 0);
    check("abort_dz", dz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("abort_no_done", seen, 0);
    check("abort_idle", ready, 1);

    run_op("post_rst", 20'h021BE, 4'd7, TRUNC ? 16'h04D0 : 16'h04D2, 4'd0, 1'b0, 1'b0, N + 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
